// File: rtl/sa_cell_sequencer_if.sv
// ----------------------------------------------------------------------------
// sa_cell_sequencer_if
// Command and upstream-data handshake bundle for sa_cell_sequencer.
//
// Signals
//   cmd_valid   : command offered by the controller
//   cmd_ready   : sequencer idle; command taken on cmd_valid & cmd_ready
//   cmd_op      : 0=LOAD 1=MAC 2=EWISE 3=DRAIN
//   cmd_count   : words (LOAD/EWISE) or cycles (MAC/DRAIN) for the command
//   cmd_wd_base : first weight-buffer pop index used by MAC
//   cmd_sub     : add_sub value held for the whole command
//   src_data    : upstream data word
//   src_valid   : upstream word valid
//   src_ready   : word consumed on src_valid & src_ready
//
// Modports
//   master : controller / data source side (drives cmd_* and src_data/valid)
//   slave  : sequencer side (drives cmd_ready and src_ready)
// ----------------------------------------------------------------------------
interface sa_cell_sequencer_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int WD_BUFFER_DEPTH = 16,
    parameter int COUNT_WIDTH     = 8
);
    localparam int WD_AW = (WD_BUFFER_DEPTH > 1) ? $clog2(WD_BUFFER_DEPTH) : 1;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [COUNT_WIDTH-1:0] cmd_count;
    logic [WD_AW-1:0]       cmd_wd_base;
    logic                   cmd_sub;
    logic [DATA_WIDTH-1:0]  src_data;
    logic                   src_valid;
    logic                   src_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_wd_base, cmd_sub,
        output src_data, src_valid,
        input  cmd_ready, src_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_wd_base, cmd_sub,
        input  src_data, src_valid,
        output cmd_ready, src_ready
    );
endinterface

// File: rtl/sa_cell_sequencer.sv
// ----------------------------------------------------------------------------
// sa_cell_sequencer
// Command-driven control source for one sa_cell (or a column of sa_cells).
// Accepts one command at a time (LOAD, MAC, EWISE, DRAIN), drives the cell's
// ctrl word, pop indices, add_sub and the data_in stream fed from an upstream
// valid/ready source, and pulses o_done once a command has completed.
//
// Ports
//   i_clk                         clock
//   i_rst                         synchronous reset, active-high
//   bus (sa_cell_sequencer_if.slave) command and upstream data handshakes
//   o_ctrl[CTRL_WIDTH]            cell ctrl word
//   o_data_in[DATA_WIDTH]         cell data stream
//   o_data_in_valid               cell data stream valid
//   o_wd_buffer_pop_index         cell weight buffer pop index
//   o_input_buffer_pop_index      cell input buffer pop index
//   o_partials_buffer_pop_index   cell partials buffer pop index
//   o_add_sub                     cell adder add/subtract select
//   o_done                        one-cycle completion pulse
//   o_busy_cycles[32]             (SA_SEQ_PERF_CNT_EN only) non-idle cycles
//   o_stall_cycles[32]            (SA_SEQ_PERF_CNT_EN only) starved stream cycles
//
// Configuration macro
//   SA_SEQ_PERF_CNT_EN : adds saturating busy/stall performance counters.
//
// All cell-facing outputs and cmd_ready are registered; src_ready is
// combinational from the registered FSM state and remaining count.
// ----------------------------------------------------------------------------
module sa_cell_sequencer #(
    parameter int DATA_WIDTH            = 16,
    parameter int CTRL_WIDTH            = 9,
    parameter int WD_BUFFER_DEPTH       = 16,
    parameter int INPUT_BUFFER_DEPTH    = 2,
    parameter int PARTIALS_BUFFER_DEPTH = 2,
    parameter int COUNT_WIDTH           = 8,
    localparam int WD_AW = (WD_BUFFER_DEPTH > 1) ? $clog2(WD_BUFFER_DEPTH) : 1,
    localparam int IN_AW = (INPUT_BUFFER_DEPTH > 1) ? $clog2(INPUT_BUFFER_DEPTH) : 1,
    localparam int PS_AW = (PARTIALS_BUFFER_DEPTH > 1) ? $clog2(PARTIALS_BUFFER_DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sa_cell_sequencer_if.slave    bus,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [DATA_WIDTH-1:0] o_data_in,
    output logic                  o_data_in_valid,
    output logic [WD_AW-1:0]      o_wd_buffer_pop_index,
    output logic [IN_AW-1:0]      o_input_buffer_pop_index,
    output logic [PS_AW-1:0]      o_partials_buffer_pop_index,
    output logic                  o_add_sub,
    output logic                  o_done
`ifdef SA_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           o_busy_cycles,
    output logic [31:0]           o_stall_cycles
`endif
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_EWISE = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Constant cell ctrl words; a stall word is the active word with the
    // three push bits [8:6] cleared so the cell buffers do not advance.
    localparam logic [CTRL_WIDTH-1:0] CTRL_LOAD  = CTRL_WIDTH'(9'h040);
    localparam logic [CTRL_WIDTH-1:0] CTRL_MAC   = CTRL_WIDTH'(9'h18B);
    localparam logic [CTRL_WIDTH-1:0] CTRL_EWISE = CTRL_WIDTH'(9'h0A0);
    localparam logic [CTRL_WIDTH-1:0] CTRL_DRAIN = CTRL_WIDTH'(9'h000);
    localparam logic [CTRL_WIDTH-1:0] CTRL_PUSH  = CTRL_WIDTH'(9'h1C0);

    // Control state
    logic [2:0]             r_state;
    logic [2:0]             w_state_next;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [COUNT_WIDTH-1:0] w_remaining_next;
    logic [WD_AW-1:0]       r_wd_idx;
    logic [WD_AW-1:0]       w_wd_idx_next;
    logic [IN_AW-1:0]       r_in_idx;
    logic [IN_AW-1:0]       w_in_idx_next;
    logic [PS_AW-1:0]       r_ps_idx;
    logic [PS_AW-1:0]       w_ps_idx_next;
    logic                   r_sub;
    logic                   w_sub_next;
    logic                   r_cmd_ready;
    logic [2:0]             w_op_state;

    // Registered cell-facing outputs and their next values
    logic [CTRL_WIDTH-1:0]  r_ctrl;
    logic [CTRL_WIDTH-1:0]  w_ctrl_next;
    logic [DATA_WIDTH-1:0]  r_data_in;
    logic [DATA_WIDTH-1:0]  w_data_next;
    logic                   r_data_in_valid;
    logic                   w_dv_next;
    logic [WD_AW-1:0]       r_wd_pop;
    logic [WD_AW-1:0]       w_wd_pop_next;
    logic [IN_AW-1:0]       r_in_pop;
    logic [IN_AW-1:0]       w_in_pop_next;
    logic [PS_AW-1:0]       r_ps_pop;
    logic [PS_AW-1:0]       w_ps_pop_next;
    logic                   r_add_sub;
    logic                   w_add_sub_next;
    logic                   r_done;
    logic                   w_done_next;

    // Handshake qualifiers
    logic w_accept;
    logic w_busy;
    logic w_active;
    logic w_streaming;
    logic w_take;

    // A command still has words/cycles left while r_remaining is non-zero;
    // once it reaches zero the FSM spends one more cycle to return to IDLE,
    // which is where done is raised.
    assign w_busy      = (r_state != ST_IDLE);
    assign w_active    = w_busy && (r_remaining != {COUNT_WIDTH{1'b0}});
    assign w_streaming = w_active && ((r_state == ST_LOAD) || (r_state == ST_EWISE));
    assign w_take      = w_streaming && bus.src_valid;
    assign w_accept    = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.src_ready = w_streaming;

    // Decode the command opcode into the busy state it starts
    always_comb begin
        w_op_state = ST_IDLE;
        case (bus.cmd_op)
            2'd0:    w_op_state = ST_LOAD;
            2'd1:    w_op_state = ST_MAC;
            2'd2:    w_op_state = ST_EWISE;
            2'd3:    w_op_state = ST_DRAIN;
            default: w_op_state = ST_IDLE;
        endcase
    end

    // FSM next-state, remaining count and MAC index sequencing
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_wd_idx_next    = r_wd_idx;
        w_in_idx_next    = r_in_idx;
        w_ps_idx_next    = r_ps_idx;
        w_sub_next       = r_sub;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Everything about the command is latched here; later
                    // cmd_* activity is ignored until IDLE again.
                    w_state_next     = w_op_state;
                    w_remaining_next = bus.cmd_count;
                    w_wd_idx_next    = bus.cmd_wd_base;
                    w_in_idx_next    = {IN_AW{1'b0}};
                    w_ps_idx_next    = {PS_AW{1'b0}};
                    w_sub_next       = bus.cmd_sub;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD, ST_EWISE: begin
                if (r_remaining == {COUNT_WIDTH{1'b0}}) begin
                    w_state_next = ST_IDLE;
                end else if (bus.src_valid) begin
                    w_remaining_next = r_remaining - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    w_remaining_next = r_remaining;
                end
            end
            ST_MAC: begin
                if (r_remaining == {COUNT_WIDTH{1'b0}}) begin
                    w_state_next = ST_IDLE;
                end else begin
                    // Indices wrap naturally at the power-of-two buffer depths
                    w_remaining_next = r_remaining - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                    w_wd_idx_next    = r_wd_idx + {{(WD_AW-1){1'b0}}, 1'b1};
                    w_in_idx_next    = r_in_idx + {{(IN_AW-1){1'b0}}, 1'b1};
                    w_ps_idx_next    = r_ps_idx + {{(PS_AW-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                if (r_remaining == {COUNT_WIDTH{1'b0}}) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_remaining_next = r_remaining - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_remaining_next = {COUNT_WIDTH{1'b0}};
            end
        endcase
    end

    // Next values of the cell-facing outputs
    always_comb begin
        w_ctrl_next   = {CTRL_WIDTH{1'b0}};
        w_data_next   = r_data_in;
        w_dv_next     = 1'b0;
        w_wd_pop_next = {WD_AW{1'b0}};
        w_in_pop_next = {IN_AW{1'b0}};
        w_ps_pop_next = {PS_AW{1'b0}};
        if (w_active) begin
            w_add_sub_next = r_sub;
            case (r_state)
                ST_LOAD: begin
                    if (w_take) begin
                        w_ctrl_next = CTRL_LOAD;
                        w_data_next = bus.src_data;
                        w_dv_next   = 1'b1;
                    end else begin
                        w_ctrl_next = CTRL_LOAD & ~CTRL_PUSH;
                    end
                end
                ST_EWISE: begin
                    if (w_take) begin
                        w_ctrl_next = CTRL_EWISE;
                        w_data_next = bus.src_data;
                        w_dv_next   = 1'b1;
                    end else begin
                        w_ctrl_next = CTRL_EWISE & ~CTRL_PUSH;
                    end
                end
                ST_MAC: begin
                    w_ctrl_next   = CTRL_MAC;
                    w_wd_pop_next = r_wd_idx;
                    w_in_pop_next = r_in_idx;
                    w_ps_pop_next = r_ps_idx;
                end
                ST_DRAIN: begin
                    w_ctrl_next = CTRL_DRAIN;
                end
                default: begin
                    w_ctrl_next = {CTRL_WIDTH{1'b0}};
                end
            endcase
        end else begin
            w_add_sub_next = 1'b0;
        end
        // Busy with nothing left means this edge returns the FSM to IDLE
        w_done_next = w_busy && (r_remaining == {COUNT_WIDTH{1'b0}});
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_remaining     <= {COUNT_WIDTH{1'b0}};
            r_wd_idx        <= {WD_AW{1'b0}};
            r_in_idx        <= {IN_AW{1'b0}};
            r_ps_idx        <= {PS_AW{1'b0}};
            r_sub           <= 1'b0;
            r_cmd_ready     <= 1'b0;
            r_ctrl          <= {CTRL_WIDTH{1'b0}};
            r_data_in       <= {DATA_WIDTH{1'b0}};
            r_data_in_valid <= 1'b0;
            r_wd_pop        <= {WD_AW{1'b0}};
            r_in_pop        <= {IN_AW{1'b0}};
            r_ps_pop        <= {PS_AW{1'b0}};
            r_add_sub       <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_remaining     <= w_remaining_next;
            r_wd_idx        <= w_wd_idx_next;
            r_in_idx        <= w_in_idx_next;
            r_ps_idx        <= w_ps_idx_next;
            r_sub           <= w_sub_next;
            // Ready tracks the state being entered so it is high exactly in IDLE
            r_cmd_ready     <= (w_state_next == ST_IDLE);
            r_ctrl          <= w_ctrl_next;
            r_data_in       <= w_data_next;
            r_data_in_valid <= w_dv_next;
            r_wd_pop        <= w_wd_pop_next;
            r_in_pop        <= w_in_pop_next;
            r_ps_pop        <= w_ps_pop_next;
            r_add_sub       <= w_add_sub_next;
            r_done          <= w_done_next;
        end
    end

    assign o_ctrl                      = r_ctrl;
    assign o_data_in                   = r_data_in;
    assign o_data_in_valid             = r_data_in_valid;
    assign o_wd_buffer_pop_index       = r_wd_pop;
    assign o_input_buffer_pop_index    = r_in_pop;
    assign o_partials_buffer_pop_index = r_ps_pop;
    assign o_add_sub                   = r_add_sub;
    assign o_done                      = r_done;

`ifdef SA_SEQ_PERF_CNT_EN
    logic [31:0] r_busy_cycles;
    logic [31:0] r_stall_cycles;

    // Saturating busy and starved-stream counters, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy_cycles  <= 32'h0000_0000;
            r_stall_cycles <= 32'h0000_0000;
        end else begin
            if (w_busy && (r_busy_cycles != 32'hFFFF_FFFF)) begin
                r_busy_cycles <= r_busy_cycles + 32'h0000_0001;
            end else begin
                r_busy_cycles <= r_busy_cycles;
            end
            if (w_streaming && !bus.src_valid && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'h0000_0001;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
        end
    end

    assign o_busy_cycles  = r_busy_cycles;
    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule
